// File: rtl/hdmi_sync_supervisor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : hdmi_sync_supervisor
// Description : Sequences reset/retrain of the R/G/B pixel-sync trackers and
//               qualifies link lock; publishes a 32-bit status word.
// Revision    : 1.0 - initial release
// ============================================================================
module hdmi_sync_supervisor #(
    parameter int RESET_CYCLES  = 16,
    parameter int LOCK_TIMEOUT  = 1048576,
    parameter int STABLE_CYCLES = 1024,
    parameter int LOSS_CYCLES   = 8
) (
    input  logic        i_pix_clk,
    input  logic        i_reset,
    input  logic        i_enable,
    input  logic        i_retrain,
    input  logic [4:0]  i_sync_r,
    input  logic [4:0]  i_sync_g,
    input  logic [4:0]  i_sync_b,
    output logic        o_sync_reset,
    output logic        o_locked,
    output logic [31:0] o_status
);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_rstw   = 3'd1;
    localparam logic [2:0] c_st_wait   = 3'd2;
    localparam logic [2:0] c_st_verify = 3'd3;
    localparam logic [2:0] c_st_locked = 3'd4;

    localparam logic [23:0] c_rst_last    = 24'(RESET_CYCLES - 1);
    localparam logic [23:0] c_tmo_last    = 24'(LOCK_TIMEOUT - 1);
    localparam logic [23:0] c_stable_last = 24'(STABLE_CYCLES - 1);
    localparam logic [23:0] c_loss_last   = 24'(LOSS_CYCLES - 1);

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [23:0] r_cnt;
    logic [23:0] w_next_cnt;
    logic [15:0] r_retrains;
    logic [15:0] w_next_retrains;
    logic [7:0]  r_timeouts;
    logic [7:0]  w_next_timeouts;
    logic [11:0] r_snapshot;
    logic [11:0] w_next_snapshot;
    logic        w_all_lk;
    logic [11:0] w_slips;
    logic        w_retrain_evt;
    logic        w_timeout_evt;

    assign w_all_lk = i_sync_r[4] & i_sync_g[4] & i_sync_b[4];
    assign w_slips  = {i_sync_r[3:0], i_sync_g[3:0], i_sync_b[3:0]};

    always_comb begin
        w_next_state    = r_state;
        w_next_cnt      = r_cnt + 24'd1;
        w_next_snapshot = r_snapshot;
        w_retrain_evt   = 1'b0;
        w_timeout_evt   = 1'b0;
        if (!i_enable) begin
            w_next_state = c_st_idle;
            w_next_cnt   = '0;
        end else if (i_retrain && ((r_state == c_st_wait) || (r_state == c_st_verify) ||
                                   (r_state == c_st_locked))) begin
            w_next_state  = c_st_rstw;
            w_next_cnt    = '0;
            w_retrain_evt = 1'b1;
        end else if (i_retrain && (r_state == c_st_rstw)) begin
            w_next_cnt = '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    w_next_state = c_st_rstw;
                    w_next_cnt   = '0;
                end
                c_st_rstw: begin
                    if (r_cnt == c_rst_last) begin
                        w_next_state = c_st_wait;
                        w_next_cnt   = '0;
                    end
                end
                c_st_wait: begin
                    // Lock beats a coincident timeout.
                    if (w_all_lk) begin
                        w_next_state    = c_st_verify;
                        w_next_cnt      = '0;
                        w_next_snapshot = w_slips;
                    end else if (r_cnt == c_tmo_last) begin
                        w_next_state  = c_st_rstw;
                        w_next_cnt    = '0;
                        w_timeout_evt = 1'b1;
                    end
                end
                c_st_verify: begin
                    if (w_all_lk && (w_slips == r_snapshot)) begin
                        if (r_cnt == c_stable_last) begin
                            w_next_state = c_st_locked;
                            w_next_cnt   = '0;
                        end
                    end else begin
                        w_next_state = c_st_wait;
                        w_next_cnt   = '0;
                    end
                end
                c_st_locked: begin
                    if (w_all_lk) begin
                        w_next_cnt = '0;
                        if (w_slips != r_snapshot) begin
                            w_next_state  = c_st_rstw;
                            w_retrain_evt = 1'b1;
                        end
                    end else if (r_cnt == c_loss_last) begin
                        w_next_state  = c_st_rstw;
                        w_next_cnt    = '0;
                        w_retrain_evt = 1'b1;
                    end
                end
                default: begin
                    w_next_state = c_st_rstw;
                    w_next_cnt   = '0;
                end
            endcase
        end
    end

    assign w_next_retrains = (w_retrain_evt && (r_retrains != 16'hFFFF)) ? r_retrains + 16'd1
                                                                         : r_retrains;
    assign w_next_timeouts = (w_timeout_evt && (r_timeouts != 8'hFF)) ? r_timeouts + 8'd1
                                                                      : r_timeouts;

    // Outputs are registered from next-state values so they align with r_state.
    always_ff @(posedge i_pix_clk) begin
        if (i_reset) begin
            r_state      <= c_st_rstw;
            r_cnt        <= '0;
            r_retrains   <= '0;
            r_timeouts   <= '0;
            r_snapshot   <= '0;
            o_sync_reset <= 1'b1;
            o_locked     <= 1'b0;
            o_status     <= {c_st_rstw, 29'd0};
        end else begin
            r_state      <= w_next_state;
            r_cnt        <= w_next_cnt;
            r_retrains   <= w_next_retrains;
            r_timeouts   <= w_next_timeouts;
            r_snapshot   <= w_next_snapshot;
            o_sync_reset <= (w_next_state == c_st_idle) || (w_next_state == c_st_rstw);
            o_locked     <= (w_next_state == c_st_locked);
            o_status     <= {w_next_state, (w_next_state == c_st_locked), 4'd0,
                             w_next_timeouts, w_next_retrains};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hdmi_sync_supervisor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_hdmi_sync_supervisor
// Description : Directed and randomized bench for hdmi_sync_supervisor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hdmi_sync_supervisor;

    localparam int RC = 4;
    localparam int LT = 32;
    localparam int SC = 8;
    localparam int LC = 3;

    localparam int IDLE   = 0;
    localparam int RSTW   = 1;
    localparam int WAIT   = 2;
    localparam int VERIFY = 3;
    localparam int LOCKED = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        retrain;
    logic [4:0]  ch_r;
    logic [4:0]  ch_g;
    logic [4:0]  ch_b;
    logic        sync_reset;
    logic        locked;
    logic [31:0] status;

    int checks   = 0;
    int failures = 0;

    int          m_state;
    int          m_time;
    int          m_retr;
    int          m_tmo;
    logic [11:0] m_snap;

    hdmi_sync_supervisor #(
        .RESET_CYCLES (RC),
        .LOCK_TIMEOUT (LT),
        .STABLE_CYCLES(SC),
        .LOSS_CYCLES  (LC)
    ) dut (
        .i_pix_clk   (clk),
        .i_reset     (rst),
        .i_enable    (en),
        .i_retrain   (retrain),
        .i_sync_r    (ch_r),
        .i_sync_g    (ch_g),
        .i_sync_b    (ch_b),
        .o_sync_reset(sync_reset),
        .o_locked    (locked),
        .o_status    (status)
    );

    always #5 clk = ~clk;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Model tracks phase and time spent in it; counters saturate.
    task automatic enter(input int st);
        m_state = st;
        m_time  = 0;
    endtask

    task automatic bump_retr();
        if (m_retr < 65535) m_retr = m_retr + 1;
    endtask

    task automatic model_step();
        logic        lk;
        logic [11:0] sl;
        lk = ch_r[4] & ch_g[4] & ch_b[4];
        sl = {ch_r[3:0], ch_g[3:0], ch_b[3:0]};
        if (rst) begin
            enter(RSTW);
            m_retr = 0;
            m_tmo  = 0;
            m_snap = '0;
            return;
        end
        if (!en) begin
            enter(IDLE);
            return;
        end
        if (retrain && m_state >= WAIT) begin
            bump_retr();
            enter(RSTW);
            return;
        end
        if (retrain && m_state == RSTW) begin
            m_time = 0;
            return;
        end
        m_time = m_time + 1;
        case (m_state)
            IDLE: enter(RSTW);
            RSTW: if (m_time == RC) enter(WAIT);
            WAIT: begin
                if (lk) begin
                    m_snap = sl;
                    enter(VERIFY);
                end else if (m_time == LT) begin
                    if (m_tmo < 255) m_tmo = m_tmo + 1;
                    enter(RSTW);
                end
            end
            VERIFY: begin
                if (lk && sl == m_snap) begin
                    if (m_time == SC) enter(LOCKED);
                end else begin
                    enter(WAIT);
                end
            end
            LOCKED: begin
                if (lk) begin
                    m_time = 0;
                    if (sl != m_snap) begin
                        bump_retr();
                        enter(RSTW);
                    end
                end else if (m_time == LC) begin
                    bump_retr();
                    enter(RSTW);
                end
            end
            default: enter(RSTW);
        endcase
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] e;
        e = (32'(m_state) << 29) | (32'(m_tmo) << 16) | 32'(m_retr);
        if (m_state == LOCKED) e = e | 32'h1000_0000;
        return e;
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check1("sync_reset", sync_reset, (m_state == IDLE) || (m_state == RSTW));
        check1("locked", locked, m_state == LOCKED);
        check32("status", status, exp_status());
    endtask

    task automatic set_ch(input logic [4:0] v);
        ch_r = v;
        ch_g = v;
        ch_b = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    function automatic logic [4:0] rand_ch();
        logic [4:0] v;
        v[4]   = ($urandom_range(0, 49) != 0);
        v[3:0] = ($urandom_range(0, 99) == 0) ? 4'($urandom_range(0, 15)) : 4'd3;
        return v;
    endfunction

    initial begin
        rst     = 1'b1;
        en      = 1'b1;
        retrain = 1'b0;
        set_ch(5'h13);
        m_state = RSTW;
        m_time  = 0;
        m_retr  = 0;
        m_tmo   = 0;
        m_snap  = '0;

        // Reset state
        cyc();
        cyc();
        check32("reset_status", status, 32'h2000_0000);
        check1("reset_sync_reset", sync_reset, 1'b1);

        // Acquisition from reset release
        rst = 1'b0;
        for (int i = 1; i <= 13; i++) begin
            cyc();
            check1("acq_sync_reset", sync_reset, i < 4);
            check1("acq_locked", locked, i >= 13);
        end
        check32("acq_status", status, 32'h9000_0000);

        // Short lock dropout tolerated, third low cycle retrains
        ch_g = 5'h03;
        cyc();
        cyc();
        ch_g = 5'h13;
        cyc();
        check32("dropout2_status", status, 32'h9000_0000);
        ch_g = 5'h03;
        cyc();
        cyc();
        check1("dropout3_pre_locked", locked, 1'b1);
        cyc();
        check32("dropout3_status", status, 32'h2000_0001);
        check1("dropout3_locked", locked, 1'b0);
        ch_g = 5'h13;

        // Slip change while LOCKED
        do_reset();
        repeat (13) cyc();
        check32("slip_pre_status", status, 32'h9000_0000);
        ch_b = 5'h14;
        cyc();
        check32("slip_locked_status", status, 32'h2000_0001);

        // Slip change during VERIFY
        ch_b = 5'h13;
        do_reset();
        repeat (7) cyc();
        check32("verify_status", status, 32'h6000_0000);
        ch_b = 5'h14;
        cyc();
        check32("slip_verify_status", status, 32'h4000_0000);
        cyc();
        check32("reverify_status", status, 32'h6000_0000);
        repeat (8) cyc();
        check32("relock_status", status, 32'h9000_0000);

        // Retrain coincident with red loss count reaching LOSS_CYCLES
        ch_r = 5'h03;
        cyc();
        cyc();
        retrain = 1'b1;
        cyc();
        retrain = 1'b0;
        check32("retrain_loss_status", status, 32'h2000_0001);
        ch_r = 5'h13;
        en   = 1'b0;
        cyc();
        check32("disable_status", status, 32'h0000_0001);
        check1("disable_sync_reset", sync_reset, 1'b1);
        en = 1'b1;

        // Five CPU retrains, then reset mid-VERIFY
        set_ch(5'h03);
        do_reset();
        repeat (4) cyc();
        for (int k = 0; k < 5; k++) begin
            retrain = 1'b1;
            cyc();
            retrain = 1'b0;
            repeat (4) cyc();
        end
        set_ch(5'h13);
        cyc();
        cyc();
        check32("verify_retr5_status", status, 32'h6000_0005);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check32("midreset_status", status, 32'h2000_0000);
        check1("midreset_sync_reset", sync_reset, 1'b1);

        // Acquisition timeouts and saturation
        set_ch(5'h03);
        do_reset();
        repeat (RC + LT) cyc();
        check32("timeout1_status", status, 32'h2001_0000);
        repeat (RC + LT) cyc();
        check32("timeout2_status", status, 32'h2002_0000);
        repeat ((RC + LT) * 254) cyc();
        check32("timeout255_status", status, 32'h20FF_0000);
        repeat (RC + LT) cyc();
        check32("timeout_sat_status", status, 32'h20FF_0000);

        // Randomized operation against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst     = ($urandom_range(0, 999) == 0);
            en      = ($urandom_range(0, 99) != 0);
            retrain = ($urandom_range(0, 199) == 0);
            ch_r    = rand_ch();
            ch_g    = rand_ch();
            ch_b    = rand_ch();
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
